// File: rtl/fpu_result_arbiter.sv
// fpu_result_arbiter: round-robin funnel from N_UNITS FPU execution units into
// one registered result slot (value, IEEE flags, source index).
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high. A producer holds valid and its payload stable until it sees
// ready; a consumer may raise or drop ready at any time. ready_out here
// depends combinationally on valid_in and ready_in, so a unit must never make
// its valid depend on its own ready.
module fpu_result_arbiter #(
  parameter  int N_UNITS = 4,
  localparam int IDX_W   = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_UNITS-1:0]     valid_in,
  output logic [N_UNITS-1:0]     ready_out,
  input  logic [32*N_UNITS-1:0]  data_in,
  input  logic [5*N_UNITS-1:0]   flags_in,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [31:0]            float_out,
  output logic [4:0]             fflags_out,
  output logic [IDX_W-1:0]       src_out
);

  // Rotating priority pointer: the unit scanned first in the current cycle.
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   ptr_next;

  // The output slot can take a new result when empty or being drained now.
  logic               slot_free;

  logic [N_UNITS-1:0] grant;
  logic               grant_any;
  logic [IDX_W-1:0]   grant_idx;
  logic [31:0]        sel_data;
  logic [4:0]         sel_flags;

  assign slot_free = !valid_out || ready_in;

  // Scan units ptr, ptr+1, ... (mod N_UNITS); the first requester wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    sel_data  = '0;
    sel_flags = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      // ptr < N_UNITS, so one conditional subtract gives the modulo.
      idx = int'(ptr) + k;
      if (idx >= N_UNITS) idx = idx - N_UNITS;
      if (!grant_any && valid_in[idx]) begin
        grant_any      = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = idx[IDX_W-1:0];
        sel_data       = data_in[32*idx +: 32];
        sel_flags      = flags_in[5*idx +: 5];
      end
    end
  end

  // Pointer moves just past the winner; explicit wrap handles non-power-of-two.
  always_comb begin
    ptr_next = '0;
    if (int'(grant_idx) != N_UNITS - 1) ptr_next = grant_idx + IDX_W'(1);
  end

  // Only the winner is told ready, and only when the slot can take it.
  always_comb begin
    ready_out = '0;
    if (slot_free) ready_out = grant;
  end

  // Output slot and pointer: capture beats drain so there is no bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out  <= 1'b0;
      float_out  <= '0;
      fflags_out <= '0;
      src_out    <= '0;
      ptr        <= '0;
    end else if (grant_any && slot_free) begin
      valid_out  <= 1'b1;
      float_out  <= sel_data;
      fflags_out <= sel_flags;
      src_out    <= grant_idx;
      ptr        <= ptr_next;
    end else if (valid_out && ready_in) begin
      valid_out  <= 1'b0;
      float_out  <= '0;
      fflags_out <= '0;
      src_out    <= '0;
    end
  end

endmodule

// File: tb/tb_fpu_result_arbiter.sv
// Bench for fpu_result_arbiter: directed test-plan steps followed by random
// traffic, checked against a transaction-level reference model.
module tb_fpu_result_arbiter;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT (N_UNITS = 4) ----------------
  logic [N-1:0]    valid_in = '0;
  logic [N-1:0]    ready_out;
  logic [32*N-1:0] data_in = '0;
  logic [5*N-1:0]  flags_in = '0;
  logic            valid_out;
  logic            ready_in = 1'b1;
  logic [31:0]     float_out;
  logic [4:0]      fflags_out;
  logic [1:0]      src_out;

  fpu_result_arbiter #(.N_UNITS(4)) dut (
    .clk(clk), .reset(reset),
    .valid_in(valid_in), .ready_out(ready_out),
    .data_in(data_in), .flags_in(flags_in),
    .valid_out(valid_out), .ready_in(ready_in),
    .float_out(float_out), .fflags_out(fflags_out), .src_out(src_out)
  );

  // ---------------- DUT (N_UNITS = 3) ----------------
  logic [2:0]  v3 = '0;
  logic [2:0]  r3;
  logic [95:0] d3 = {32'h33333333, 32'h22222222, 32'h11111111};
  logic [14:0] f3 = {5'd3, 5'd2, 5'd1};
  logic        vo3;
  logic        ri3 = 1'b1;
  logic [31:0] fo3;
  logic [4:0]  ff3;
  logic [1:0]  so3;

  fpu_result_arbiter #(.N_UNITS(3)) dut3 (
    .clk(clk), .reset(reset),
    .valid_in(v3), .ready_out(r3),
    .data_in(d3), .flags_in(f3),
    .valid_out(vo3), .ready_in(ri3),
    .float_out(fo3), .fflags_out(ff3), .src_out(so3)
  );

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Output slot contents plus the rotating start index, at transaction level.
  int          m_ptr = 0;
  bit          m_valid = 0;
  logic [31:0] m_data = '0;
  logic [4:0]  m_flags = '0;
  int          m_src = 0;
  int          m_last_g = -1;
  logic [38:0] exp_q[$];   // {src, flags, data} of accepted results, in order

  function automatic int model_grant(input logic [N-1:0] vin, input int start);
    for (int k = 0; k < N; k++)
      if (vin[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_data = '0; m_flags = '0; m_src = 0;
    exp_q.delete();
  endtask

  task automatic set_unit(input int i, input logic [31:0] d, input logic [4:0] f);
    data_in[32*i +: 32] = d;
    flags_in[5*i +: 5]  = f;
  endtask

  // One clock cycle; called #1 after a rising edge with inputs already set.
  task automatic cycle();
    int g;
    bit slot;
    logic [N-1:0] exp_ro;
    logic [38:0] item;
    g      = model_grant(valid_in, m_ptr);
    slot   = !m_valid || ready_in;
    exp_ro = '0;
    if (g >= 0 && slot) exp_ro[g] = 1'b1;
    #4;
    chk("ready_out", 40'(ready_out), 40'(exp_ro));
    if (valid_out && ready_in) begin
      if (exp_q.size() == 0) chk("sb_underflow", 40'(1), 40'(0));
      else begin
        item = exp_q.pop_front();
        chk("sb_result", 40'({src_out, fflags_out, float_out}), 40'(item));
      end
    end
    m_last_g = -1;
    if (g >= 0 && slot) begin
      m_valid = 1; m_data = data_in[32*g +: 32]; m_flags = flags_in[5*g +: 5];
      m_src = g; m_ptr = (g + 1) % N; m_last_g = g;
      exp_q.push_back({2'(g), m_flags, m_data});
    end else if (m_valid && ready_in) begin
      m_valid = 0; m_data = '0; m_flags = '0; m_src = 0;
    end
    @(posedge clk); #1;
    chk("valid_out", 40'(valid_out), 40'(m_valid));
    chk("float_out", 40'(float_out), 40'(m_data));
    chk("fflags_out", 40'(fflags_out), 40'(m_flags));
    chk("src_out", 40'(src_out), 40'(m_src));
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic step3(input logic [2:0] vin, input logic [2:0] exp_ro,
                       input logic [1:0] exp_src, input logic [31:0] exp_data);
    v3 = vin;
    #4;
    chk("n3_ready_out", 40'(r3), 40'(exp_ro));
    @(posedge clk); #1;
    chk("n3_src_out", 40'(so3), 40'(exp_src));
    chk("n3_float_out", 40'(fo3), 40'(exp_data));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_src_seq[5];
    int n;
    bit [N-1:0] pending;
    exp_src_seq = '{0, 1, 2, 3, 0};

    // Reset state
    #1;
    chk("rst_valid_out", 40'(valid_out), 40'(0));
    chk("rst_float_out", 40'(float_out), 40'(0));
    chk("rst_fflags_out", 40'(fflags_out), 40'(0));
    chk("rst_src_out", 40'(src_out), 40'(0));
    chk("rst_ready_out", 40'(ready_out), 40'(0));
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // Single request from unit 0, then idle drain
    set_unit(0, 32'h3F800000, 5'b00001);
    valid_in = 4'b0001; ready_in = 1'b1;
    cycle();
    chk("single_valid", 40'(valid_out), 40'(1));
    chk("single_float", 40'(float_out), 40'(32'h3F800000));
    chk("single_flags", 40'(fflags_out), 40'(5'b00001));
    chk("single_src", 40'(src_out), 40'(0));
    valid_in = '0;
    cycle();
    chk("drain_valid", 40'(valid_out), 40'(0));
    chk("drain_float", 40'(float_out), 40'(0));

    // All units requesting: 0,1,2,3,0 back to back
    apply_reset();
    for (int i = 0; i < N; i++) set_unit(i, 32'h40000000 + i, 5'(i));
    valid_in = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("rr_valid", 40'(valid_out), 40'(1));
      chk("rr_src_seq", 40'(src_out), 40'(exp_src_seq[c]));
    end

    // Backpressure: hold unit 1 result while unit 2 waits
    set_unit(1, 32'hBF800000, 5'b00010);
    valid_in = 4'b0010;
    cycle();
    chk("bp_load_src", 40'(src_out), 40'(1));
    set_unit(2, 32'h40490FDB, 5'b00100);
    valid_in = 4'b0100; ready_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("bp_hold_float", 40'(float_out), 40'(32'hBF800000));
    end
    ready_in = 1'b1;
    cycle();
    chk("bp_release_src", 40'(src_out), 40'(2));
    chk("bp_release_float", 40'(float_out), 40'(32'h40490FDB));
    valid_in = '0;
    cycle();

    // Starvation: unit 0 always requests, unit 3 requests once until served
    set_unit(0, 32'h3F800000, 5'b00000);
    set_unit(3, 32'h7FC00000, 5'b10000);
    valid_in = 4'b1001;
    n = 0;
    while (n < 8) begin
      cycle();
      n++;
      if (m_last_g == 3) break;
    end
    chk("starve_bound", 40'(n <= 2), 40'(1));
    chk("starve_src", 40'(src_out), 40'(3));
    chk("starve_flags", 40'(fflags_out), 40'(5'b10000));
    chk("starve_float", 40'(float_out), 40'(32'h7FC00000));
    valid_in = '0;
    cycle();

    // Three-unit build: pointer wrap 2 -> 0 -> 1, never 3
    apply_reset();
    step3(3'b010, 3'b010, 2'd1, 32'h22222222);
    step3(3'b101, 3'b100, 2'd2, 32'h33333333);
    step3(3'b101, 3'b001, 2'd0, 32'h11111111);
    step3(3'b111, 3'b010, 2'd1, 32'h22222222);
    step3(3'b111, 3'b100, 2'd2, 32'h33333333);
    step3(3'b111, 3'b001, 2'd0, 32'h11111111);
    v3 = '0;

    // Asynchronous reset while a stalled result is held
    apply_reset();
    set_unit(1, 32'hC0000000, 5'b01000);
    valid_in = 4'b0010; ready_in = 1'b1;
    cycle();
    valid_in = '0; ready_in = 1'b0;
    cycle();
    chk("arst_pre_valid", 40'(valid_out), 40'(1));
    reset = 1'b1;
    #1;
    chk("arst_valid", 40'(valid_out), 40'(0));
    chk("arst_float", 40'(float_out), 40'(0));
    chk("arst_flags", 40'(fflags_out), 40'(0));
    chk("arst_src", 40'(src_out), 40'(0));
    #1 reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    ready_in = 1'b1; valid_in = 4'b1111;
    cycle();
    chk("arst_ptr_zero", 40'(src_out), 40'(0));
    valid_in = '0;
    cycle();

    // Random traffic: units hold a result until accepted
    pending = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && $urandom_range(0, 1) == 1) begin
          pending[i] = 1'b1;
          set_unit(i, $urandom(), 5'($urandom_range(0, 31)));
        end
      end
      valid_in = pending;
      ready_in = ($urandom_range(0, 3) != 0);
      cycle();
      if (m_last_g >= 0) pending[m_last_g] = 1'b0;
    end

    // Drain everything and confirm the scoreboard emptied
    valid_in = '0; ready_in = 1'b1;
    cycle();
    cycle();
    chk("sb_empty", 40'(exp_q.size()), 40'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_result_arbiter.md
Name: fpu_result_arbiter

Overview:
- Collects finished results from the FPU's execution units (sign modifier, adder, multiplier, divider/sqrt, converter, classifier, ...) and funnels them into a single registered result stream toward integer/FP writeback.
- Sits directly downstream of every unit's valid_out/ready_in/float_out handshake.
- Round-robin arbitration keeps multi-cycle units from starving.
- One registered output slot with full throughput: one result per cycle when the consumer is ready.

Parameters:
- N_UNITS, 4, number of producing execution units (>=2).
- IDX_W, $clog2(N_UNITS), width of source index (derived, not overridden).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous reset, active-high
- valid_in  input  N_UNITS  per-unit result valid (unit's valid_out)
- ready_out  output  N_UNITS  per-unit accept (drives unit's ready_in)
- data_in  input  32*N_UNITS  per-unit result; unit i at bits [32*i+31:32*i]
- flags_in  input  5*N_UNITS  per-unit IEEE flags {NV,DZ,OF,UF,NX}; unit i at [5*i+4:5*i]
- valid_out  output  1  registered result valid
- ready_in  input  1  writeback accepts result
- float_out  output  32  registered result
- fflags_out  output  5  registered flags
- src_out  output  IDX_W  index of unit that produced current result

Behaviour:
- Reset (async, immediate):
  - valid_out=0, float_out=32'h00000000, fflags_out=5'b0, src_out=0.
  - Priority pointer ptr=0.
  - Reset mid-transfer discards the held result; upstream units are reset by the same signal.
- slot_free = !valid_out || ready_in (combinational).
- Grant (combinational):
  - Scan indices ptr, ptr+1, ..., wrapping modulo N_UNITS.
  - First i with valid_in[i]=1 is granted.
  - ready_out[i] = slot_free && grant[i]; all other ready_out bits 0.
  - At most one ready_out bit high per cycle.
  - ready_out may depend combinationally on valid_in and ready_in. Units must not make valid_in depend on their ready_out.
- Capture (posedge clk, when any grant and slot_free):
  - valid_out<=1; float_out<=data_in[g]; fflags_out<=flags_in[g]; src_out<=g.
  - ptr <= (g+1) mod N_UNITS. Wrap from N_UNITS-1 to 0; non-power-of-two N_UNITS must wrap correctly.
- Drain (valid_out && ready_in, no grant):
  - valid_out<=0; float_out<=0; fflags_out<=0; src_out<=0; ptr unchanged.
- Stall (valid_out && !ready_in):
  - Outputs held stable; all ready_out=0; ptr unchanged.
- Simultaneous drain and capture: the new result replaces the old in the same edge (no bubble).
- No request: ptr unchanged; registers unchanged unless draining.
- Latency: result accepted at edge k appears on valid_out/float_out after edge k (1 cycle).
- Throughput: 1 result/cycle with ready_in held high.
- Ordering:
  - No ordering guarantee across units.
  - Per-unit order is preserved, since each unit presents one result at a time.
- Fairness: a continuously requesting unit is granted within N_UNITS accepted transfers.
- Data is not modified (no NaN canonicalisation). flags_in pass through unchanged.

Test Plan:
- Reset then single request: valid_in=4'b0001, data_in[0]=32'h3F800000, flags 5'b00001, ready_in=1.
  - Expect ready_out=4'b0001 in that cycle.
  - Next cycle: valid_out=1, float_out=32'h3F800000, fflags_out=5'b00001, src_out=0.
  - Following cycle with no request: valid_out=0, float_out=0.
- All four units request continuously, ready_in=1: grants cycle 0,1,2,3,0; src_out sequence 0,1,2,3,0 on consecutive cycles with no bubbles.
- Backpressure: output holds 32'hBF800000 from unit 1, ready_in=0 for 3 cycles while unit 2 requests.
  - Expect ready_out=0, float_out stable for 3 cycles.
  - When ready_in=1: unit 2 granted same cycle; next cycle float_out=unit 2 data, src_out=2.
- Starvation check: unit 0 requests every cycle, unit 3 asserts valid once with 32'h7FC00000, flags 5'b10000.
  - Unit 3 granted within 2 accepted transfers; its result appears with src_out=3, fflags_out=5'b10000.
- N_UNITS=3 build: requests on units 2 and 0 with ptr=2.
  - Expect grant 2 then 0 (wrap); ptr wraps to 0 then 1, never reaching 3.
- Async reset asserted while valid_out=1 and ready_in=0: valid_out, float_out, fflags_out, src_out drop to 0 immediately, before the next clock edge; after release, ptr=0.
